qdiv_seq: RTL and testbench

//  Sequential fixed-point divider: quotient = dividend / divisor, using the same

---
 rtl/fixed_pt_pkg.sv | 29 ++
 rtl/qdiv_seq.sv | 153 +++++++++++++++
 tb/tb_qdiv_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_pt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_pt_pkg
//  Brief    : Shared definitions for the sign-magnitude fixed-point datapaths
//             (default Q-format, divider state encoding, sign helper).
//  Revision : 1.0
// ============================================================================
package fixed_pt_pkg;

  // Default format: 8-bit word, sign bit plus 7 magnitude bits, 6 fractional.
  localparam int Q_DEFAULT = 6;
  localparam int N_DEFAULT = 8;

  // Divider controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result sign in sign-magnitude form: XOR of the operand signs, forced
  // to 0 when the magnitude is zero so that -0 is never produced.
  function automatic logic sm_sign(input logic sign_a, input logic sign_b,
                                   input logic mag_nonzero);
    return (sign_a ^ sign_b) & mag_nonzero;
  endfunction

endpackage : fixed_pt_pkg
`default_nettype wire

// File: rtl/qdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : qdiv_seq
//  Brief    : Sequential restoring divider for sign-magnitude Q-format values.
//             One quotient bit per clock, start/busy/done handshake, result
//             saturates on overflow and flags division by zero.
//  Revision : 1.0
// ============================================================================
module qdiv_seq
  import fixed_pt_pkg::*;
#(
  parameter int Q = Q_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic         overflow_o,
  output logic         div_zero_o
);

  // The magnitude is shifted left by Q before dividing so that the integer
  // quotient already carries Q fractional bits.
  localparam int ITERS = N - 1 + Q;
  localparam int CW    = $clog2(ITERS);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [ITERS-1:0]   wdvd_q;     // working dividend, consumed MSB first
  logic [N-1:0]       rem_q;      // partial remainder, one guard bit
  logic [ITERS-1:0]   raw_q;      // unsaturated quotient
  logic [N-2:0]       dvs_q;      // |divisor|
  logic               sa_q;
  logic               sb_q;
  logic               dz_flag_q;
  logic               busy_q;
  logic               done_q;
  logic [N-1:0]       quot_q;
  logic               ovf_q;
  logic               dz_q;

  logic [N:0]         step_d;     // {quotient bit, new remainder}
  logic               ovf_d;
  logic [N-2:0]       mag_d;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The guard bit can only be set when the
  // shifted remainder certainly exceeds the divisor.
  function automatic logic [N:0] restore_step(input logic [N-1:0] rem,
                                              input logic [N-2:0] dvs,
                                              input logic         din);
    logic [N-1:0] t;
    logic         ge;
    t  = {rem[N-2:0], din};
    ge = rem[N-1] | (t >= {1'b0, dvs});
    if (ge) begin
      return {1'b1, t - {1'b0, dvs}};
    end else begin
      return {1'b0, t};
    end
  endfunction

  // Next restoring step and saturated result magnitude.
  always_comb begin
    step_d = restore_step(rem_q, dvs_q, wdvd_q[ITERS-1]);
    ovf_d  = |raw_q[ITERS-1:N-1];
    mag_d  = ovf_d ? {(N-1){1'b1}} : raw_q[N-2:0];
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wdvd_q    <= '0;
      rem_q     <= '0;
      raw_q     <= '0;
      dvs_q     <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      dz_flag_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sa_q   <= dividend_i[N-1];
            sb_q   <= divisor_i[N-1];
            dvs_q  <= divisor_i[N-2:0];
            wdvd_q <= {dividend_i[N-2:0], {Q{1'b0}}};
            rem_q  <= '0;
            raw_q  <= '0;
            cnt_q  <= CW'(ITERS - 1);
            if (divisor_i[N-2:0] == '0) begin
              dz_flag_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              dz_flag_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          rem_q  <= step_d[N-1:0];
          raw_q  <= {raw_q[ITERS-2:0], step_d[N]};
          wdvd_q <= {wdvd_q[ITERS-2:0], 1'b0};
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b1;
          if (dz_flag_q) begin
            // Full-scale magnitude is never zero, so the sign is the plain XOR.
            quot_q <= {sa_q ^ sb_q, {(N-1){1'b1}}};
            ovf_q  <= 1'b0;
            dz_q   <= 1'b1;
          end else begin
            quot_q <= {sm_sign(sa_q, sb_q, |mag_d), mag_d};
            ovf_q  <= ovf_d;
            dz_q   <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quot_q;
  assign overflow_o = ovf_q;
  assign div_zero_o = dz_q;

endmodule : qdiv_seq
`default_nettype wire

// File: tb/tb_qdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qdiv_seq
//  Brief    : Directed and randomised self-checking bench for qdiv_seq
//             (Q=6, N=8, 1.0 = 0x40).
//  Revision : 1.0
// ============================================================================
module tb_qdiv_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] dividend_i = 8'h00;
  logic [7:0] divisor_i = 8'h00;
  logic       busy_o;
  logic       done_o;
  logic [7:0] quotient_o;
  logic       overflow_o;
  logic       div_zero_o;

  int tests = 0;
  int fails = 0;

  qdiv_seq #(.Q(6), .N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quotient_o (quotient_o),
    .overflow_o (overflow_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor(|a|*2^6/|b|), saturate at 0x7F, no negative zero.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic o, output logic z);
    int ma, mb, raw, mag;
    logic s;
    ma = int'(a[6:0]);
    mb = int'(b[6:0]);
    s  = a[7] ^ b[7];
    if (mb == 0) begin
      q = {s, 7'h7F};
      o = 1'b0;
      z = 1'b1;
    end else begin
      raw = (ma * 64) / mb;
      o   = (raw > 127);
      mag = o ? 127 : raw;
      z   = 1'b0;
      q   = {s & (mag != 0), 7'(mag)};
    end
  endtask

  // Present operands for exactly one rising edge, then scramble them.
  task automatic start_pulse(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    dividend_i = ~a;
    divisor_i  = ~b;
  endtask

  // Called just after the accepting edge; measures latency and busy length.
  task automatic wait_done(input int elat, input logic [7:0] eq, input logic eo,
                           input logic ez, input string tag);
    int n, bc;
    logic got;
    n = 0; bc = 0; got = 1'b0;
    while (!got && n < 40) begin
      if (busy_o) bc++;
      @(posedge clk);
      #1;
      n++;
      if (done_o) got = 1'b1;
    end
    chk({tag, " done seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(elat));
    chk({tag, " busy cycles"}, 32'(bc), ez ? 32'd0 : 32'(elat - 1));
    chk({tag, " quotient"}, 32'(quotient_o), 32'(eq));
    chk({tag, " overflow"}, 32'(overflow_o), 32'(eo));
    chk({tag, " div_zero"}, 32'(div_zero_o), 32'(ez));
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic eo, input logic ez, input string tag);
    start_pulse(a, b);
    wait_done(ez ? 1 : 14, eq, eo, ez, tag);
  endtask

  initial begin
    int n, bc;
    logic got;
    logic [7:0] ra, rb, mq;
    logic mo, mz;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset quotient", 32'(quotient_o), 32'd0);
    chk("reset overflow", 32'(overflow_o), 32'd0);
    chk("reset div_zero", 32'(div_zero_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic division: 0.75 / 1.5 = 0.5
    run_op(8'h30, 8'h60, 8'h20, 1'b0, 1'b0, "t1 0x30/0x60");
    @(posedge clk);
    #1;
    chk("t1 done one cycle", 32'(done_o), 32'd0);
    chk("t1 quotient held", 32'(quotient_o), 32'h20);

    // Sign handling
    run_op(8'hA0, 8'h40, 8'hA0, 1'b0, 1'b0, "t2 0xA0/0x40");
    run_op(8'h20, 8'hC0, 8'hA0, 1'b0, 1'b0, "t2 0x20/0xC0");
    run_op(8'hA0, 8'hC0, 8'h20, 1'b0, 1'b0, "t2 0xA0/0xC0");
    run_op(8'h00, 8'hC0, 8'h00, 1'b0, 1'b0, "t2 0x00/0xC0");

    // Saturation
    run_op(8'h40, 8'h20, 8'h7F, 1'b1, 1'b0, "t3 0x40/0x20");
    run_op(8'hC0, 8'h20, 8'hFF, 1'b1, 1'b0, "t3 0xC0/0x20");
    run_op(8'h7F, 8'h01, 8'h7F, 1'b1, 1'b0, "t3 0x7F/0x01");

    // Division by +0 and -0
    run_op(8'h40, 8'h00, 8'h7F, 1'b0, 1'b1, "t4 0x40/0x00");
    run_op(8'hC0, 8'h00, 8'hFF, 1'b0, 1'b1, "t4 0xC0/0x00");
    run_op(8'h40, 8'h80, 8'hFF, 1'b0, 1'b1, "t4 0x40/0x80");

    // Start while busy and during the DONE cycle is ignored; start held
    // through the done cycle is then accepted back-to-back.
    start_pulse(8'h30, 8'h60);
    n = 0; bc = 0; got = 1'b0;
    while (!got && n < 40) begin
      if (busy_o) bc++;
      if (n == 5 || n == 13) begin
        start_i    = 1'b1;
        dividend_i = 8'h40;
        divisor_i  = 8'h20;
      end else if (n == 6) begin
        start_i = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (done_o) got = 1'b1;
    end
    chk("t5 done seen", 32'(got), 32'd1);
    chk("t5 latency", 32'(n), 32'd14);
    chk("t5 busy cycles", 32'(bc), 32'd13);
    chk("t5 quotient", 32'(quotient_o), 32'h20);
    chk("t5 overflow", 32'(overflow_o), 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(14, 8'h7F, 1'b1, 1'b0, "t5 back-to-back");

    // Back-to-back through the normal handshake
    run_op(8'h60, 8'h40, 8'h60, 1'b0, 1'b0, "t5 b2b-a");
    run_op(8'h10, 8'h40, 8'h10, 1'b0, 1'b0, "t5 b2b-b");
    run_op(8'h7F, 8'h01, 8'h7F, 1'b1, 1'b0, "t5 b2b-c");

    // Reset in the middle of CALC
    start_pulse(8'h30, 8'h60);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("t6 busy before reset", 32'(busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 busy in reset", 32'(busy_o), 32'd0);
    chk("t6 quotient in reset", 32'(quotient_o), 32'd0);
    chk("t6 overflow in reset", 32'(overflow_o), 32'd0);
    chk("t6 div_zero in reset", 32'(div_zero_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t6 no done in reset", 32'(done_o), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      chk("t6 no done after abort", 32'(done_o), 32'd0);
    end
    run_op(8'h60, 8'h40, 8'h60, 1'b0, 1'b0, "t6 after reset");

    // Random sweep against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 6 == 0) rb = {rb[7], 7'h00};
      else if (i % 6 == 1) rb = {rb[7], 7'(rb[2:0])};
      model(ra, rb, mq, mo, mz);
      run_op(ra, rb, mq, mo, mz, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_qdiv_seq
`default_nettype wire
